// File: rtl/subs_arbiter_if.sv
// subs_arbiter_if: requester, substractor and result signals of the two-port subtract arbiter
interface subs_arbiter_if #(parameter int WIDTH = 4);
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [WIDTH-1:0] sub_a, sub_b, sub_diff, res_diff;
  logic             sub_carry, res_valid, res_id, res_carry, res_ack, busy;
  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, sub_diff, sub_carry, res_ack,
    output req0_ready, req1_ready, sub_a, sub_b, res_valid, res_id, res_diff, res_carry, busy
  );
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, sub_diff, sub_carry, res_ack,
    input  req0_ready, req1_ready, sub_a, sub_b, res_valid, res_id, res_diff, res_carry, busy
  );
endinterface

// File: rtl/subs_arbiter.sv
// subs_arbiter: round-robin arbiter sharing one external substractor between two requesters
module subs_arbiter #(parameter int WIDTH = 4) (
  input logic        clk,
  input logic        reset,
  subs_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, HOLD = 2'd3;
  logic [1:0]       r_state, w_next;
  logic [WIDTH-1:0] r_op_a, r_op_b, r_res_diff;
  logic             r_last_grant, r_res_valid, r_res_id, r_res_carry;
  logic             w_idle, w_gnt0, w_gnt1, w_acc0, w_acc1, w_acc;
  // grant in IDLE only (never while reset is high); ties go to the requester not served last
  always_comb begin
    w_idle = (r_state == IDLE) && !reset;
    w_gnt0 = bus.req0_valid && (!bus.req1_valid || r_last_grant);
    w_gnt1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    w_acc0 = w_idle && w_gnt0;
    w_acc1 = w_idle && w_gnt1;
    w_acc  = w_acc0 || w_acc1;
    w_next = (r_state == IDLE)    ? (w_acc ? ISSUE : IDLE) :
             (r_state == ISSUE)   ? CAPTURE :
             (r_state == CAPTURE) ? HOLD :
             (bus.res_ack ? IDLE : HOLD);
  end
  // state, operand latch on acceptance, result capture one cycle after issue
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_last_grant <= 1'b1;
      r_res_valid  <= 1'b0;
      r_res_diff   <= '0;
      r_res_carry  <= 1'b0;
      r_res_id     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_res_valid <= (w_next == HOLD);
      if (w_acc) begin
        r_op_a       <= w_acc1 ? bus.req1_a : bus.req0_a;
        r_op_b       <= w_acc1 ? bus.req1_b : bus.req0_b;
        r_last_grant <= w_acc1;
      end
      if (r_state == CAPTURE) begin
        r_res_diff  <= bus.sub_diff;
        r_res_carry <= bus.sub_carry;
        r_res_id    <= r_last_grant;
      end
    end
  end
  assign bus.req0_ready = w_acc0;
  assign bus.req1_ready = w_acc1;
  assign bus.sub_a      = r_op_a;
  assign bus.sub_b      = r_op_b;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_id     = r_res_id;
  assign bus.res_diff   = r_res_diff;
  assign bus.res_carry  = r_res_carry;
  assign bus.busy       = (r_state != IDLE);
endmodule

// File: tb/tb_subs_arbiter.sv
// tb_subs_arbiter: vector table, corner sequences and random traffic against a transaction-level model
module tb_subs_arbiter;
  logic clk = 0, reset = 1, flip = 0, m_last = 1, mon_en = 0, after_ack = 0;
  logic p_chg_ok = 1;
  logic [3:0] p_sub_a, p_sub_b;
  int n_cmp = 0, n_err = 0;

  typedef struct {
    logic v0; logic [3:0] a0, b0;
    logic v1; logic [3:0] a1, b1;
    int hold; logic eid; logic [3:0] ediff; logic ec;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  subs_arbiter_if #(.WIDTH(4)) bus();
  subs_arbiter #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  assign bus.sub_diff  = bus.sub_a - bus.sub_b;
  assign bus.sub_carry = (bus.sub_a < bus.sub_b) ^ flip;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready_both", bus.req0_ready & bus.req1_ready, 0);
      chk("ready_busy", (bus.req0_ready | bus.req1_ready) & bus.busy, 0);
      if (!p_chg_ok) begin
        chk("sub_a_stable", bus.sub_a, p_sub_a);
        chk("sub_b_stable", bus.sub_b, p_sub_b);
      end
    end
    p_sub_a  = bus.sub_a;
    p_sub_b  = bus.sub_b;
    p_chg_ok = reset | (bus.req0_ready & bus.req0_valid) | (bus.req1_ready & bus.req1_valid);
  end

  task automatic run_op(input logic v0, input logic [3:0] a0, b0, input logic v1, input logic [3:0] a1, b1,
                        input logic keep, input int hold, input logic ack_early,
                        output logic id, output logic [3:0] gd, output logic gc);
    logic eid, ok, ec;
    logic [3:0] ea, eb, ed;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
    eid = (v0 && v1) ? ~m_last : v1;
    ea = eid ? a1 : a0;
    eb = eid ? b1 : b0;
    ed = 4'((int'(ea) - int'(eb) + 16) % 16);
    ec = (ea < eb) ^ flip;
    ok = 0; id = 0; gd = 0; gc = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (bus.req0_ready && bus.req0_valid) begin ok = 1; id = 0; end
      else if (bus.req1_ready && bus.req1_valid) begin ok = 1; id = 1; end
      if (n == 0 && after_ack) begin
        chk("rv_after_ack", bus.res_valid, 0);
        chk("accept_after_ack", ok, 1);
      end
    end
    after_ack = 0;
    if (!ok) begin chk("accept_timeout", 0, 1); return; end
    chk("grant_id", id, eid);
    m_last = eid;
    @(posedge clk); #1;
    if (!keep) begin bus.req0_valid = 0; bus.req1_valid = 0; end
    bus.res_ack = ack_early;
    @(negedge clk); chk("rv_T1", bus.res_valid, 0); chk("busy_T1", bus.busy, 1);
    @(posedge clk); #1; bus.res_ack = 0;
    @(negedge clk); chk("rv_T2", bus.res_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rv_T3", bus.res_valid, 1);
    chk("res_id", bus.res_id, eid);
    chk("res_diff", bus.res_diff, ed);
    chk("res_carry", bus.res_carry, ec);
    gd = bus.res_diff; gc = bus.res_carry;
    flip = ~flip;
    repeat (hold) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rv_hold", bus.res_valid, 1);
      chk("id_hold", bus.res_id, eid);
      chk("diff_hold", bus.res_diff, ed);
      chk("carry_hold", bus.res_carry, ec);
    end
    flip = ~flip;
    @(posedge clk); #1; bus.res_ack = 1;
    @(posedge clk); #1; bus.res_ack = 0;
    after_ack = 1;
  endtask

  task automatic reset_abort(input int k);
    logic ok, id;
    logic [3:0] gd;
    logic gc;
    ok = 0;
    bus.req0_valid = 1; bus.req0_a = 4'b0101; bus.req0_b = 4'b0011;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = bus.req0_ready;
    end
    if (!ok) chk("abort_accept_timeout", 0, 1);
    @(posedge clk); #1; bus.req0_valid = 0;
    repeat (k) begin @(posedge clk); #1; end
    reset = 1;
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    chk("abort_rv", bus.res_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_sub_a", bus.sub_a, 0);
    chk("abort_sub_b", bus.sub_b, 0);
    chk("abort_diff", bus.res_diff, 0);
    m_last = 1; after_ack = 0;
    @(posedge clk); #1;
    run_op(1, 4'b0110, 4'b0010, 1, 4'b0011, 4'b0001, 0, 0, 0, id, gd, gc);
    chk("abort_then_req0", id, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic id, gc, v0, v1;
    logic [3:0] gd;
    tbl[0] = '{1, 4'b1101, 4'b1000, 1, 4'b0010, 4'b0001, 0, 0, 4'b0101, 0};
    tbl[1] = '{1, 4'b1101, 4'b1000, 1, 4'b0010, 4'b0001, 0, 1, 4'b0001, 0};
    tbl[2] = '{1, 4'b0001, 4'b0001, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0};
    tbl[3] = '{0, 4'b0000, 4'b0000, 1, 4'b0010, 4'b1001, 5, 1, 4'b1001, 1};
    tbl[4] = '{1, 4'b0000, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 4'b0001, 1};
    tbl[5] = '{1, 4'b0111, 4'b0011, 1, 4'b1111, 4'b0000, 1, 1, 4'b1111, 0};
    bus.req0_valid = 1; bus.req1_valid = 1; bus.res_ack = 0;
    bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0;
    @(negedge clk);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_rv", bus.res_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sub_a", bus.sub_a, 0);
    chk("rst_sub_b", bus.sub_b, 0);
    chk("rst_diff", bus.res_diff, 0);
    chk("rst_carry", bus.res_carry, 0);
    chk("rst_id", bus.res_id, 0);
    @(posedge clk); #1;
    reset = 0; bus.req0_valid = 0; bus.req1_valid = 0; m_last = 1; mon_en = 1;
    foreach (tbl[i]) begin
      run_op(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].a1, tbl[i].b1, 0, tbl[i].hold, 0, id, gd, gc);
      chk($sformatf("tbl%0d_id", i), id, tbl[i].eid);
      chk($sformatf("tbl%0d_diff", i), gd, tbl[i].ediff);
      chk($sformatf("tbl%0d_carry", i), gc, tbl[i].ec);
    end
    bus.res_ack = 1;
    @(negedge clk); chk("ack_idle_rv", bus.res_valid, 0); chk("ack_idle_busy", bus.busy, 0);
    @(posedge clk); #1; bus.res_ack = 0;
    @(negedge clk); chk("ack_idle_rv2", bus.res_valid, 0);
    @(posedge clk); #1; after_ack = 0;
    run_op(1, 4'b1010, 4'b0011, 0, 4'b0000, 4'b0000, 0, 1, 1, id, gd, gc);
    chk("ack_issue_diff", gd, 4'b0111);
    reset = 1;
    @(posedge clk); #1; reset = 0; m_last = 1; after_ack = 0;
    for (int i = 0; i < 6; i++) begin
      run_op(1, 4'b1101, 4'b1000, 1, 4'b0010, 4'b0001, 1, 0, 0, id, gd, gc);
      chk($sformatf("alt%0d_id", i), id, i % 2);
      chk($sformatf("alt%0d_diff", i), gd, (i % 2) ? 4'b0001 : 4'b0101);
    end
    bus.req0_valid = 0; bus.req1_valid = 0; after_ack = 0;
    @(posedge clk); #1;
    reset_abort(1);
    reset_abort(2);
    for (int i = 0; i < 150; i++) begin
      v0 = 1'($urandom);
      v1 = v0 ? 1'($urandom) : 1'b1;
      flip = 1'($urandom);
      run_op(v0, 4'($urandom), 4'($urandom), v1, 4'($urandom), 4'($urandom),
             0, $urandom_range(0, 2), 1'($urandom), id, gd, gc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/subs_arbiter.md
SUBS_ARBITER -- requirements
Module: subs_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width; the shared substractor datapath is 4 bits.
REQ-002 clk  input  1  rising-edge clock; one clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_a, req0_b  input  WIDTH each  requester 0 minuend and subtrahend.
REQ-006 req0_ready  output  1  requester 0 operands accepted this cycle when valid is also high.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  same as REQ-004..006, for requester 1.
REQ-008 sub_a, sub_b  output  WIDTH each  operands driven to the external shared substractor.
REQ-009 sub_diff  input  WIDTH  difference returned by the substractor.
REQ-010 sub_carry  input  1  carry returned by the substractor.
REQ-011 res_valid  output  1  result is available.
REQ-012 res_id  output  1  index of the requester that owns the result.
REQ-013 res_diff  output  WIDTH  registered difference.
REQ-014 res_carry  output  1  registered carry.
REQ-015 res_ack  input  1  consumer takes the result.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, CAPTURE and HOLD.
REQ-018 IDLE: req<n>_ready SHALL be high only for the requester granted this cycle, and low for the other.
REQ-019 Grant rule: the requester with valid high is granted; if both are valid, the requester not granted last SHALL win (round-robin).
REQ-020 On acceptance (valid&ready, cycle T), the block SHALL latch the operands into op_a/op_b, set last_grant to the winner, and go to ISSUE.
REQ-021 sub_a/sub_b SHALL be driven from op_a/op_b registers only, never directly from request ports; they hold their value in all states.
REQ-022 ISSUE (cycle T+1): operands are stable on sub_a/sub_b; the next state SHALL be CAPTURE.
REQ-023 CAPTURE (cycle T+2): the block SHALL register sub_diff into res_diff, sub_carry into res_carry and the owner into res_id, then go to HOLD.
REQ-024 HOLD: res_valid SHALL be high; res_diff, res_carry and res_id SHALL stay stable until the cycle res_ack is sampled high.
REQ-025 Latency: res_valid SHALL first be high at cycle T+3 after acceptance at T.
REQ-026 On HOLD with res_ack=1, the block SHALL return to IDLE; a new grant is possible in the next cycle, so throughput is one operation per 4 cycles minimum.
REQ-027 res_ack outside HOLD SHALL be ignored.
REQ-028 req ready SHALL be low for both requesters in ISSUE, CAPTURE and HOLD; a valid requester SHALL hold its operands until accepted.
REQ-029 Arithmetic is fully delegated to the substractor: wrap-around (a<b) results pass through mod 2^WIDTH unmodified, and carry is captured verbatim with no interpretation.
REQ-030 Starvation: with both requesters valid continuously, grants SHALL strictly alternate.

Reset
REQ-031 When reset is high at a clock edge, the block SHALL go to IDLE and clear res_valid, res_diff, res_carry, res_id, op_a, op_b (so sub_a and sub_b are 0) and busy to 0.
REQ-032 After reset, last_grant SHALL be 1, so requester 0 wins the first simultaneous request.
REQ-033 Reset in any state, including HOLD with a pending result, SHALL abort the operation; the result is lost and no ready is asserted in that cycle.

Verification
REQ-034 req0 a=0001 b=0001 alone -> accepted at T, res_valid at T+3, res_id=0, res_diff=0000, res_carry=sub_carry sampled at T+2.
REQ-035 req1 a=0010 b=1001 alone -> res_id=1, res_diff=1001 (wrap-around), held unchanged for 5 cycles with res_ack=0.
REQ-036 Both valid after reset (req0 a=1101 b=1000, req1 a=0010 b=0001) -> req0 granted first (res_diff=0101), req1 second (res_diff=0001); with both held valid, 6 grants strictly alternate 0,1,0,1,0,1.
REQ-037 Reset asserted in CAPTURE or HOLD -> next cycle state IDLE, res_valid=0, busy=0, sub_a=sub_b=0000; the next simultaneous request grants req0.
REQ-038 res_ack pulsed in IDLE and ISSUE -> no effect; res_ack in HOLD -> res_valid low the next cycle and the next request is accepted in that cycle.
REQ-039 Every cycle: ready never high for both requesters, never high outside IDLE, and sub_a/sub_b never change outside an acceptance edge or reset.
